// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage types and defaults for the register-file write port arbiter.
package wb_stage_pkg;

  localparam int WB_DEPTH_DEF        = 2;
  localparam int WB_STARVE_LIMIT_DEF = 4;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_en;
  } wb_stage_out_t;

  // One buffered long-latency (mul/div) result waiting for the write port.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_res_entry_t;

endpackage

// File: rtl/wb_res_fifo.sv
// In-order result buffer: registered count drives full/empty, no pass-through.
module wb_res_fifo
  import wb_stage_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_res_entry_t         push_entry,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output wb_res_entry_t         head,
  output logic [DEPTH-1:0]      occ,
  output logic [DEPTH-1:0][4:0] slot_rd
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  wb_res_entry_t mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr      <= wr_ptr + AW'(1);
        occ[wr_ptr] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        occ[rd_ptr] <= 1'b0;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by occ alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Expose each slot's destination so the owner can build a hazard mask.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) slot_rd[i] = mem[i].rd;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline and buffered mul/div results.
module wb_port_arbiter
  import wb_stage_pkg::*;
#(
  parameter int DEPTH        = WB_DEPTH_DEF,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  wb_stage_out_t wb_in,
  input  logic          md_valid,
  input  logic [4:0]    md_rd,
  input  logic [31:0]   md_data,
  output logic          md_ready,
  output logic          rf_we,
  output logic [4:0]    rf_waddr,
  output logic [31:0]   rf_wdata,
  output logic          wb_hold,
  output logic [31:0]   pend_mask
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  head_grant;
  logic                  pipe_eff;
  wb_res_entry_t         fifo_head;
  wb_res_entry_t         push_entry;
  logic [DEPTH-1:0]      occ;
  logic [DEPTH-1:0][4:0] slot_rd;
  logic [3:0]            starve_cnt;

  assign md_ready   = !fifo_full;
  // Results for x0 are handshaken but never stored.
  assign fifo_push  = md_valid && md_ready && (md_rd != 5'd0);
  assign push_entry = '{rd: md_rd, data: md_data};
  assign pipe_eff   = wb_in.wb_en && (wb_in.wb_rd != 5'd0);
  assign head_grant = !pipe_eff && !fifo_empty;
  assign wb_hold    = (starve_cnt == LIMIT);

  wb_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (head_grant),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head),
    .occ        (occ),
    .slot_rd    (slot_rd)
  );

  // Port mux: the pipeline always wins; the buffer head only fills idle slots.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (pipe_eff) begin
      rf_we    = 1'b1;
      rf_waddr = wb_in.wb_rd;
      rf_wdata = wb_in.wb_data;
    end else if (head_grant) begin
      rf_we    = 1'b1;
      rf_waddr = fifo_head.rd;
      rf_wdata = fifo_head.data;
    end
  end

  // Count consecutive cycles the waiting head lost the port, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst || fifo_empty || head_grant) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Hazard mask: one bit per destination still waiting in the buffer.
  always_comb begin
    pend_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i]) pend_mask[slot_rd[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

endmodule
